// File: rtl/schedule_pkg.sv
// Shared types for the dual-issue scheduler.
// Issue record, unit encoding, FSM states and RV32I opcodes.
package schedule_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    U_ALU    = 4'd0,
    U_LSU    = 4'd1,
    U_BRANCH = 4'd2,
    U_JUMP   = 4'd3,
    U_SYSTEM = 4'd4
  } unit_e;

  typedef enum logic {
    PAIR   = 1'b0,
    SECOND = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    unit_e           unit;
    logic [9:0]      pad;
  } issue_rec_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/schedule_if.sv
// Fetch-packet in, issue records / redirect / stall out.
// master drives fetch_data; slave is the scheduler.
interface schedule_if;
  import schedule_pkg::*;

  logic [127:0]    fetch_data;
  issue_rec_t      instr1;
  issue_rec_t      instr2;
  logic            write1;
  logic            write2;
  logic            jal;
  logic [XLEN-1:0] jal_addr;
  logic            stall;

  modport master (
    output fetch_data,
    input  instr1, instr2, write1, write2,
    input  jal, jal_addr, stall
  );

  modport slave (
    input  fetch_data,
    output instr1, instr2, write1, write2,
    output jal, jal_addr, stall
  );
endinterface

// File: rtl/schedule_predecode.sv
// Combinational pre-decode of one slot into an issue record.
// Ports: instr/pc in, rec out.
module schedule_predecode
  import schedule_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output issue_rec_t      rec
);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            has_rd;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  always_comb begin
    rec          = '0;
    rec.pc       = pc;
    rec.instr    = instr;
    rec.unit     = U_SYSTEM;
    has_rd       = 1'b0;
    unique case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        rec.imm  = imm_u;
        rec.unit = U_ALU;
        has_rd   = 1'b1;
      end
      OP_JAL: begin
        rec.imm  = imm_j;
        rec.unit = U_JUMP;
        has_rd   = 1'b1;
      end
      OP_JALR: begin
        rec.imm      = imm_i;
        rec.unit     = U_JUMP;
        rec.rs1_used = 1'b1;
        has_rd       = 1'b1;
      end
      OP_BRANCH: begin
        rec.imm      = imm_b;
        rec.unit     = U_BRANCH;
        rec.rs1_used = 1'b1;
        rec.rs2_used = 1'b1;
      end
      OP_LOAD: begin
        rec.imm      = imm_i;
        rec.unit     = U_LSU;
        rec.rs1_used = 1'b1;
        has_rd       = 1'b1;
      end
      OP_STORE: begin
        rec.imm      = imm_s;
        rec.unit     = U_LSU;
        rec.rs1_used = 1'b1;
        rec.rs2_used = 1'b1;
      end
      OP_IMM: begin
        rec.imm      = imm_i;
        rec.unit     = U_ALU;
        rec.rs1_used = 1'b1;
        has_rd       = 1'b1;
      end
      OP_REG: begin
        rec.unit     = U_ALU;
        rec.rs1_used = 1'b1;
        rec.rs2_used = 1'b1;
        has_rd       = 1'b1;
      end
      OP_FENCE: begin
        rec.imm  = imm_i;
      end
      OP_SYSTEM: begin
        rec.imm      = imm_i;
        rec.rs1_used = 1'b1;
        has_rd       = 1'b1;
      end
      default: begin
      end
    endcase
    rec.rd    = has_rd ? instr[11:7] : 5'd0;
    rec.rs1   = rec.rs1_used ? instr[19:15] : 5'd0;
    rec.rs2   = rec.rs2_used ? instr[24:20] : 5'd0;
    rec.rd_we = has_rd && (instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/schedule.sv
// Dual-issue scheduler: pre-decode, pair hazard check, PAIR/SECOND FSM.
// Ports: clk, rst_n, bus (schedule_if.slave).
module schedule
  import schedule_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  schedule_if.slave bus
);

  state_e          state, n_state;
  issue_rec_t      rec_a, rec_b;
  issue_rec_t      n_i1, n_i2;
  logic            n_w1, n_w2, n_jal, n_stall;
  logic [XLEN-1:0] n_addr, tgt_a, tgt_b;
  logic            bub_a, bub_b, jal_a, jal_b;
  logic            raw, waw, lsu2, ctl, hazard, issue_b;

  schedule_predecode u_pd_a (
    .instr (bus.fetch_data[63:32]),
    .pc    (bus.fetch_data[31:0]),
    .rec   (rec_a)
  );

  schedule_predecode u_pd_b (
    .instr (bus.fetch_data[127:96]),
    .pc    (bus.fetch_data[95:64]),
    .rec   (rec_b)
  );

  assign bub_a = rec_a.instr == 32'h0;
  assign bub_b = rec_b.instr == 32'h0;
  assign jal_a = rec_a.instr[6:0] == OP_JAL;
  assign jal_b = rec_b.instr[6:0] == OP_JAL;
  assign tgt_a = rec_a.pc + rec_a.imm;
  assign tgt_b = rec_b.pc + rec_b.imm;

  assign raw = rec_a.rd_we &&
    ((rec_b.rs1_used && rec_b.rs1 == rec_a.rd) ||
     (rec_b.rs2_used && rec_b.rs2 == rec_a.rd));
  assign waw = rec_a.rd_we && rec_b.rd_we &&
    (rec_a.rd == rec_b.rd);
  assign lsu2 = (rec_a.unit == U_LSU) &&
    (rec_b.unit == U_LSU);
  assign ctl = rec_a.unit inside
    {U_BRANCH, U_JUMP, U_SYSTEM};
  assign hazard = !bub_a && !bub_b &&
    (raw || waw || lsu2 || ctl);
  // B goes out with A unless blocked; alone if A is a bubble
  assign issue_b = !bub_b && (bub_a || !hazard);

  always_comb begin
    n_state = state;
    n_i1    = '0;
    n_i2    = '0;
    n_w1    = 1'b0;
    n_w2    = 1'b0;
    n_jal   = 1'b0;
    n_addr  = '0;
    n_stall = 1'b0;
    if (state == SECOND) begin
      n_i1    = rec_b;
      n_w1    = 1'b1;
      n_state = PAIR;
      if (jal_b) begin
        n_jal  = 1'b1;
        n_addr = tgt_b;
      end
    end else begin
      if (!bub_a) begin
        n_i1 = rec_a;
        n_w1 = 1'b1;
        if (jal_a) begin
          n_jal  = 1'b1;
          n_addr = tgt_a;
        end
      end
      if (issue_b) begin
        n_i2 = rec_b;
        n_w2 = 1'b1;
        if (jal_b) begin
          n_jal  = 1'b1;
          n_addr = tgt_b;
        end
      end else if (hazard && !jal_a) begin
        // JAL in A squashes B; otherwise B waits one cycle
        n_stall = 1'b1;
        n_state = SECOND;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PAIR;
      bus.instr1   <= '0;
      bus.instr2   <= '0;
      bus.write1   <= 1'b0;
      bus.write2   <= 1'b0;
      bus.jal      <= 1'b0;
      bus.jal_addr <= '0;
      bus.stall    <= 1'b0;
    end else begin
      state        <= n_state;
      bus.instr1   <= n_i1;
      bus.instr2   <= n_i2;
      bus.write1   <= n_w1;
      bus.write2   <= n_w2;
      bus.jal      <= n_jal;
      bus.jal_addr <= n_addr;
      bus.stall    <= n_stall;
    end
  end

endmodule

// File: tb/tb_schedule.sv
// Directed bench for the dual-issue scheduler.
// Hand-computed vectors, immediate assertions per check.
module tb_schedule;
  import schedule_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  schedule_if bus ();

  schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pkt(
    input logic [31:0] ib, input logic [31:0] pb,
    input logic [31:0] ia, input logic [31:0] pa);
    return {ib, pb, ia, pa};
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_data = pkt(32'h0001E237, 32'h4,
                         32'h00014137, 32'h0);
    #3;
    chk("rst_w1", bus.write1, 0);
    chk("rst_w2", bus.write2, 0);
    chk("rst_jal", bus.jal, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_i1", bus.instr1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // independent LUI pair
    step();
    chk("lui_w1", bus.write1, 1);
    chk("lui_w2", bus.write2, 1);
    chk("lui_jal", bus.jal, 0);
    chk("lui_addr", bus.jal_addr, 0);
    chk("lui_stall", bus.stall, 0);
    chk("lui_pc1", bus.instr1.pc, 32'h0);
    chk("lui_imm1", bus.instr1.imm, 32'h00014000);
    chk("lui_rd1", bus.instr1.rd, 2);
    chk("lui_pc2", bus.instr2.pc, 32'h4);
    chk("lui_imm2", bus.instr2.imm, 32'h0001E000);
    chk("lui_rd2", bus.instr2.rd, 4);
    chk("lui_unit", bus.instr1.unit, U_ALU);

    // RAW: addi x5,x0,1 ; add x6,x5,x5
    bus.fetch_data = pkt(32'h00528333, 32'h14,
                         32'h00100293, 32'h10);
    step();
    chk("raw1_w1", bus.write1, 1);
    chk("raw1_w2", bus.write2, 0);
    chk("raw1_stall", bus.stall, 1);
    chk("raw1_pc", bus.instr1.pc, 32'h10);
    chk("raw1_imm", bus.instr1.imm, 32'h1);
    step();
    chk("raw2_pc", bus.instr1.pc, 32'h14);
    chk("raw2_w1", bus.write1, 1);
    chk("raw2_w2", bus.write2, 0);
    chk("raw2_stall", bus.stall, 0);
    chk("raw2_rs", {bus.instr1.rs1, bus.instr1.rs2}, 10'h0A5);
    chk("raw2_imm", bus.instr1.imm, 0);

    // JAL x1,+0x100 in A; B squashed
    bus.fetch_data = pkt(32'h00100293, 32'h24,
                         32'h100000EF, 32'h20);
    step();
    chk("ja_jal", bus.jal, 1);
    chk("ja_addr", bus.jal_addr, 32'h120);
    chk("ja_w1", bus.write1, 1);
    chk("ja_w2", bus.write2, 0);
    chk("ja_stall", bus.stall, 0);
    chk("ja_unit", bus.instr1.unit, U_JUMP);
    chk("ja_rdwe", bus.instr1.rd_we, 1);

    // lui x2 @0x30 ; jal x0,+8 @0x34
    bus.fetch_data = pkt(32'h0080006F, 32'h34,
                         32'h00014137, 32'h30);
    step();
    chk("jb_w1", bus.write1, 1);
    chk("jb_w2", bus.write2, 1);
    chk("jb_jal", bus.jal, 1);
    chk("jb_addr", bus.jal_addr, 32'h3C);
    chk("jb_rdwe", bus.instr2.rd_we, 0);

    // target wraps: jal x0,+0x20 @0xFFFFFFF0
    bus.fetch_data = pkt(32'h0, 32'h0,
                         32'h0200006F, 32'hFFFFFFF0);
    step();
    chk("wrap_jal", bus.jal, 1);
    chk("wrap_addr", bus.jal_addr, 32'h10);
    chk("wrap_w2", bus.write2, 0);

    // bubble A, lui x3,1 in B
    bus.fetch_data = pkt(32'h000011B7, 32'h44,
                         32'h0, 32'h40);
    step();
    chk("bubA_w1", bus.write1, 0);
    chk("bubA_w2", bus.write2, 1);
    chk("bubA_rd", bus.instr2.rd, 3);
    chk("bubA_imm", bus.instr2.imm, 32'h1000);
    chk("bubA_stall", bus.stall, 0);

    // both bubbles
    bus.fetch_data = pkt(32'h0, 32'h4C, 32'h0, 32'h48);
    step();
    chk("bub2_w", {bus.write1, bus.write2}, 0);
    chk("bub2_stall", bus.stall, 0);
    chk("bub2_jal", bus.jal, 0);

    // unknown opcode alone in B
    bus.fetch_data = pkt(32'hFFFFFFFF, 32'h54,
                         32'h0, 32'h50);
    step();
    chk("unk_unit", bus.instr2.unit, U_SYSTEM);
    chk("unk_rdwe", bus.instr2.rd_we, 0);

    // two loads: lw x1 ; lw x2 -> LSU conflict
    bus.fetch_data = pkt(32'h00002103, 32'h64,
                         32'h00002083, 32'h60);
    step();
    chk("lsu_stall", bus.stall, 1);
    chk("lsu_w2", bus.write2, 0);
    step();
    chk("lsu2_pc", bus.instr1.pc, 32'h64);
    chk("lsu2_unit", bus.instr1.unit, U_LSU);

    // async reset while in SECOND
    bus.fetch_data = pkt(32'h00528333, 32'h14,
                         32'h00100293, 32'h10);
    step();
    chk("rs_stall", bus.stall, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_w1", bus.write1, 0);
    chk("rs_stall0", bus.stall, 0);
    chk("rs_i1", bus.instr1, 0);
    bus.fetch_data = pkt(32'h0001E237, 32'h4,
                         32'h00014137, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rs_pair_w1", bus.write1, 1);
    chk("rs_pair_w2", bus.write2, 1);
    chk("rs_pair_pc", bus.instr1.pc, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
